ysyx_24100005_ifu: RTL



---
 rtl/ysyx_24100005_pkg.sv | 19 +
 rtl/ysyx_24100005_ifu_pcgen.sv | 28 ++
 rtl/ysyx_24100005_ifu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// and the alignment mask used to detect non-word-aligned fetch addresses.
package ysyx_24100005_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ifu_state_t;

    // True when the low address bits select a non-word-aligned location.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_pcgen.sv
// Next-PC selection for the fetch unit. A redirect always wins over the
// sequential advance; with neither, the PC holds.
module ysyx_24100005_ifu_pcgen
    import ysyx_24100005_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Priority mux: redirect, then pc+4 (wraps naturally), then hold.
    always_comb begin
        next_pc = pc;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc + XLEN'(4);
        end
    end

    assign misaligned = is_misaligned(pc[1:0]);

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at
// a time and hands the fetched word to the core over a valid/ready channel.
//
// state | meaning
// FETCH | request imem at pc (or fault immediately if pc is misaligned)
// WAIT  | one request outstanding; drop=1 means its response is stale
// HOLD  | out_* valid and stable until consumed or redirected
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_t      state;
    ifu_state_t      state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            drop;
    logic            drop_nxt;
    logic            misaligned;
    logic            advance;
    logic            req_fire;
    logic            cap_en;
    logic            cap_fault;
    logic [XLEN-1:0] cap_inst;

    ysyx_24100005_ifu_pcgen #(
        .XLEN(XLEN)
    ) u_pcgen (
        .pc            (pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (advance),
        .next_pc       (pc_nxt),
        .misaligned    (misaligned)
    );

    // Sequential advance only when the held instruction is consumed.
    assign advance = (state == HOLD) && out_ready;

    // Request valid comes from registered state and pc only; the reset term
    // keeps the request quiet while the async reset is still asserted.
    assign imem_req_valid = (state == FETCH) && !misaligned && !rst;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Next-state, stale-response tracking and output capture decisions.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        cap_en    = 1'b0;
        cap_fault = 1'b0;
        cap_inst  = '0;
        case (state)
            FETCH: begin
                if (misaligned) begin
                    // A redirect replaces the bad pc before it is reported.
                    if (!redirect_valid) begin
                        state_nxt = HOLD;
                        cap_en    = 1'b1;
                        cap_fault = 1'b1;
                    end
                end else if (req_fire) begin
                    // Request left with the old pc; a same-cycle redirect
                    // makes its response stale.
                    state_nxt = WAIT;
                    drop_nxt  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        state_nxt = FETCH;
                        drop_nxt  = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        cap_en    = 1'b1;
                        cap_fault = imem_resp_err;
                        cap_inst  = imem_resp_err ? '0 : imem_resp_data;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
                drop_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, pc and stale flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
        end
    end

    // Registered output channel; payload only changes when entering HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else begin
            out_valid <= (state_nxt == HOLD);
            if (cap_en) begin
                out_inst  <= cap_inst;
                out_pc    <= pc;
                out_fault <= cap_fault;
            end
        end
    end

endmodule
